// File: rtl/bilinear_line_sched_pkg.sv
// Shared types for the bilinear vertical line scheduler.
// State encoding and remainder width helper.
package bilinear_line_sched_pkg;

  localparam int RESO_W_DEF = 12;
  localparam int FRAC_W_DEF = 6;

  function automatic int rem_width(input int reso);
    return reso + 3;
  endfunction

  localparam int REM_W = rem_width(RESO_W_DEF);

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    CALC,
    SHIFT,
    DIV,
    OUT,
    DRAIN
  } state_t;

endpackage

// File: rtl/bilinear_line_sched_frac_divider.sv
// Restoring unsigned divider producing C_FRAC_WIDTH quotient bits.
// The first step is folded into the start cycle.
module frac_divider #(
  parameter int C_WIDTH      = 15,
  parameter int C_FRAC_WIDTH = 6
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    start,
  input  logic [C_WIDTH-1:0]      dividend,
  input  logic [C_WIDTH-1:0]      divisor,
  output logic                    busy,
  output logic [C_FRAC_WIDTH-1:0] quotient
);

  localparam int CW = $clog2(C_FRAC_WIDTH + 1);

  logic [C_WIDTH-1:0]      r_q;
  logic [C_WIDTH-1:0]      d_q;
  logic [C_WIDTH-1:0]      r_in;
  logic [C_WIDTH-1:0]      d_in;
  logic [C_WIDTH-1:0]      r_sh;
  logic [C_WIDTH-1:0]      r_nx;
  logic [C_FRAC_WIDTH-1:0] q_in;
  logic [C_FRAC_WIDTH-1:0] q_nx;
  logic [CW-1:0]           cnt;
  logic                    bit_nx;

  always_comb begin
    r_in   = start ? dividend : r_q;
    d_in   = start ? divisor : d_q;
    q_in   = start ? '0 : quotient;
    r_sh   = {r_in[C_WIDTH-2:0], 1'b0};
    bit_nx = (r_sh >= d_in);
    r_nx   = bit_nx ? (r_sh - d_in) : r_sh;
    q_nx   = (q_in << 1) | C_FRAC_WIDTH'(bit_nx);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_q      <= '0;
      d_q      <= '0;
      quotient <= '0;
      cnt      <= '0;
    end else if (start) begin
      r_q      <= r_nx;
      d_q      <= divisor;
      quotient <= q_nx;
      cnt      <= CW'(C_FRAC_WIDTH - 1);
    end else if (cnt != '0) begin
      r_q      <= r_nx;
      quotient <= q_nx;
      cnt      <= cnt - CW'(1);
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/bilinear_line_sched.sv
// Vertical bilinear scheduler: walks output lines, fetches source
// lines into a two-line window and emits (top, weight) descriptors.
import bilinear_line_sched_pkg::*;

module bilinear_line_sched #(
  parameter int C_RESO_WIDTH = 12,
  parameter int C_FRAC_WIDTH = 6
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    start,
  input  logic [C_RESO_WIDTH-1:0] ori_size,
  input  logic [C_RESO_WIDTH-1:0] scale_size,
  output logic                    in_req_valid,
  input  logic                    in_req_ready,
  output logic                    o_valid,
  input  logic                    o_ready,
  output logic [C_RESO_WIDTH-1:0] o_top_idx,
  output logic [C_FRAC_WIDTH-1:0] o_weight,
  output logic                    o_last,
  output logic                    busy,
  output logic                    done
);

  localparam int N  = C_RESO_WIDTH;
  localparam int RW = rem_width(C_RESO_WIDTH);

  state_t state, state_nx;

  logic [N-1:0]           o_sz, s_sz;
  logic [N-1:0]           j, target, cur_top, fetched;
  logic [N-1:0]           need;
  logic signed [RW-1:0]   rem, two_s, two_o;
  logic                   req_v, ov, xfer;
  logic                   div_start, div_busy;
  logic                   done_r, is_last;
  logic [C_FRAC_WIDTH-1:0] div_q, weight;

  assign two_s   = $signed({2'b00, s_sz, 1'b0});
  assign two_o   = $signed({2'b00, o_sz, 1'b0});
  assign need    = (o_sz > N'(1)) ? N'(2) : N'(1);
  assign is_last = (j == s_sz - N'(1));
  assign xfer    = req_v & in_req_ready;

  always_comb begin
    state_nx  = state;
    req_v     = 1'b0;
    ov        = 1'b0;
    div_start = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && (|ori_size) && (|scale_size))
          state_nx = PRIME;
      end
      PRIME: begin
        req_v = (fetched < need);
        if (!req_v) state_nx = CALC;
      end
      CALC: begin
        if (!(rem >= two_s)) state_nx = SHIFT;
      end
      SHIFT: begin
        req_v = (cur_top < target) && (fetched < o_sz);
        if (!req_v) begin
          state_nx  = DIV;
          div_start = 1'b1;
        end
      end
      DIV: begin
        if (!div_busy) state_nx = OUT;
      end
      OUT: begin
        ov = 1'b1;
        if (o_ready) state_nx = is_last ? DRAIN : CALC;
      end
      DRAIN: begin
        req_v = (fetched < o_sz);
        if (!req_v) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      o_sz    <= '0;
      s_sz    <= '0;
      j       <= '0;
      rem     <= '0;
      target  <= '0;
      cur_top <= '0;
      fetched <= '0;
      done_r  <= 1'b0;
    end else begin
      state  <= state_nx;
      done_r <= (state == DRAIN) && (state_nx == IDLE);
      unique case (state)
        IDLE: begin
          if (state_nx == PRIME) begin
            o_sz    <= ori_size;
            s_sz    <= scale_size;
            j       <= '0;
            target  <= '0;
            cur_top <= '0;
            fetched <= '0;
            rem     <= $signed({3'b000, ori_size})
                     - $signed({3'b000, scale_size});
          end
        end
        PRIME, DRAIN: begin
          if (xfer) fetched <= fetched + N'(1);
        end
        CALC: begin
          if (state_nx == CALC) begin
            rem    <= rem - two_s;
            target <= target + N'(1);
          end
        end
        SHIFT: begin
          if (xfer) begin
            cur_top <= cur_top + N'(1);
            fetched <= fetched + N'(1);
          end
        end
        OUT: begin
          if (state_nx == CALC) begin
            rem <= rem + two_o;
            j   <= j + N'(1);
          end
        end
        default: ;
      endcase
    end
  end

  frac_divider #(
    .C_WIDTH      (RW),
    .C_FRAC_WIDTH (C_FRAC_WIDTH)
  ) u_div (
    .clk      (clk),
    .resetn   (resetn),
    .start    (div_start),
    .dividend (rem),
    .divisor  (two_s),
    .busy     (div_busy),
    .quotient (div_q)
  );

  // Centre-aligned positions before line 0 and on the last line clamp.
  assign weight = (rem[RW-1] || (target == o_sz - N'(1))) ? '0 : div_q;

  assign in_req_valid = resetn & req_v;
  assign o_valid      = resetn & ov;
  assign o_top_idx    = resetn ? target : '0;
  assign o_weight     = resetn ? weight : '0;
  assign o_last       = resetn & ov & is_last;
  assign busy         = resetn & (state != IDLE);
  assign done         = resetn & done_r;

endmodule

// File: tb/tb_bilinear_line_sched.sv
// Scoreboard bench for bilinear_line_sched: expected descriptors come
// from a closed-form position model and are popped on each handshake.
module tb_bilinear_line_sched;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [11:0] ori_size, scale_size;
  logic        in_req_valid, in_req_ready;
  logic        o_valid, o_ready;
  logic [11:0] o_top_idx;
  logic [5:0]  o_weight;
  logic        o_last, busy, done;

  typedef struct packed {
    logic [11:0] top;
    logic [5:0]  w;
    logic        last;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  bilinear_line_sched dut (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start),
    .ori_size     (ori_size),
    .scale_size   (scale_size),
    .in_req_valid (in_req_valid),
    .in_req_ready (in_req_ready),
    .o_valid      (o_valid),
    .o_ready      (o_ready),
    .o_top_idx    (o_top_idx),
    .o_weight     (o_weight),
    .o_last       (o_last),
    .busy         (busy),
    .done         (done)
  );

  // Protocol monitor: stalled valids must hold, descriptors must not move.
  logic        p_rst, p_ov, p_or, p_iv, p_ir, p_last;
  logic [11:0] p_top;
  logic [5:0]  p_w;
  initial begin
    p_rst = 0; p_ov = 0; p_or = 0; p_iv = 0; p_ir = 0;
    p_last = 0; p_top = '0; p_w = '0;
  end

  always @(negedge clk) begin
    if (resetn && p_rst && p_iv && !p_ir) begin
      vectors++;
      if (in_req_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL in_req_hold: in_req_valid=%b want 1", in_req_valid);
      end
    end
    if (resetn && p_rst && p_ov && !p_or) begin
      vectors++;
      if ({o_valid, o_top_idx, o_weight, o_last} !==
          {1'b1, p_top, p_w, p_last}) begin
        miscompares++;
        $display("FAIL o_hold: got v%b t%0d w%0d l%b want v1 t%0d w%0d l%b",
                 o_valid, o_top_idx, o_weight, o_last, p_top, p_w, p_last);
      end
    end
    p_rst = resetn; p_ov = o_valid; p_or = o_ready;
    p_iv = in_req_valid; p_ir = in_req_ready;
    p_top = o_top_idx; p_w = o_weight; p_last = o_last;
  end

  // Drives one frame, scoreboarding every descriptor handshake.
  task automatic run_frame(input int o, input int s, input bit stall,
                           input bit poke, output int fetches,
                           output int outs, output int dones);
    exp_t e;
    int   p, t, w, tmo;
    for (int j = 0; j < s; j++) begin
      p = (2 * j + 1) * o - s;
      if (p < 0) begin
        t = 0; w = 0;
      end else begin
        t = p / (2 * s);
        w = ((p - t * 2 * s) * 64) / (2 * s);
        if (t == o - 1) w = 0;
      end
      e.top = 12'(t); e.w = 6'(w); e.last = (j == s - 1);
      q.push_back(e);
    end
    fetches = 0; outs = 0; dones = 0; tmo = 0;
    ori_size = 12'(o); scale_size = 12'(s);
    in_req_ready = 1; o_ready = 1; start = 1;
    @(posedge clk); #1 start = 0;
    while (dones == 0 && tmo < 3000) begin
      if (stall) begin
        in_req_ready = 1'($urandom_range(0, 1));
        o_ready = 1'($urandom_range(0, 1));
      end
      start = poke && (outs == 1);
      if (start) begin ori_size = 12'd2; scale_size = 12'd2; end
      @(negedge clk);
      if (in_req_valid && in_req_ready) fetches++;
      if (o_valid && o_ready) begin
        outs++;
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL extra_desc: got t%0d w%0d want none",
                   o_top_idx, o_weight);
        end else begin
          e = q.pop_front();
          if ({o_top_idx, o_weight, o_last} !== e) begin
            miscompares++;
            $display("FAIL desc%0d: got t%0d w%0d l%b want t%0d w%0d l%b",
                     outs - 1, o_top_idx, o_weight, o_last,
                     e.top, e.w, e.last);
          end
        end
      end
      if (done) begin
        dones++;
        vectors++;
        if (busy !== 1'b0) begin
          miscompares++;
          $display("FAIL done_idle: busy=%b want 0", busy);
        end
      end
      @(posedge clk); #1;
      tmo++;
    end
    start = 0; in_req_ready = 1; o_ready = 1;
    @(negedge clk);
    if (done) dones++;
    q.delete();
  endtask

  task automatic test_reset;
    resetn = 0; start = 0; ori_size = '0; scale_size = '0;
    in_req_ready = 1; o_ready = 1;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if ({in_req_valid, o_valid, o_top_idx, o_weight, o_last, busy, done}
          !== 23'd0) begin
        miscompares++;
        $display("FAIL reset_outs: got %h want 0",
                 {in_req_valid, o_valid, o_top_idx, o_weight, o_last, busy, done});
      end
    end
    @(posedge clk); #1 resetn = 1;
  endtask

  task automatic test_frame(input string nm, input int o, input int s,
                            input bit stall, input bit poke);
    int f, n, d;
    run_frame(o, s, stall, poke, f, n, d);
    vectors++;
    if (f !== o) begin
      miscompares++;
      $display("FAIL %s_fetches: got %0d want %0d", nm, f, o);
    end
    vectors++;
    if (n !== s) begin
      miscompares++;
      $display("FAIL %s_outs: got %0d want %0d", nm, n, s);
    end
    vectors++;
    if (d !== 1) begin
      miscompares++;
      $display("FAIL %s_done: got %0d pulses want 1", nm, d);
    end
  endtask

  task automatic test_zero_size;
    for (int k = 0; k < 2; k++) begin
      ori_size = (k == 0) ? 12'd4 : 12'd0;
      scale_size = (k == 0) ? 12'd0 : 12'd4;
      @(posedge clk); #1 start = 1;
      @(posedge clk); #1 start = 0;
      repeat (3) begin
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || in_req_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL zero_size%0d: busy=%b req=%b want 0 0",
                   k, busy, in_req_valid);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    int outs, tmo, dones;
    outs = 0; tmo = 0; dones = 0;
    ori_size = 12'd4; scale_size = 12'd8;
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    while (tmo < 500) begin
      @(negedge clk);
      if (o_valid && outs == 2) break;
      if (o_valid && o_ready) outs++;
      tmo++;
    end
    vectors++;
    if (tmo >= 500) begin
      miscompares++;
      $display("FAIL mid_reach_out3: got timeout want 3rd OUT");
    end
    resetn = 0;
    @(posedge clk); #1;
    vectors++;
    if ({in_req_valid, o_valid, o_top_idx, o_weight, o_last, busy, done}
        !== 23'd0) begin
      miscompares++;
      $display("FAIL mid_reset_outs: got %h want 0",
               {in_req_valid, o_valid, o_top_idx, o_weight, o_last, busy, done});
    end
    repeat (2) begin
      @(negedge clk);
      if (done) dones++;
    end
    resetn = 1;
    repeat (6) begin
      @(negedge clk);
      if (done || busy || in_req_valid || o_valid) dones++;
    end
    vectors++;
    if (dones !== 0) begin
      miscompares++;
      $display("FAIL mid_no_done: got %0d active cycles want 0", dones);
    end
    test_frame("after_reset", 8, 4, 0, 0);
  endtask

  initial begin
    test_reset;
    test_frame("up_4_8", 4, 8, 0, 0);
    test_frame("down_8_4", 8, 4, 0, 0);
    test_frame("unity_5_5", 5, 5, 0, 0);
    test_frame("single_1_3", 1, 3, 0, 0);
    test_zero_size;
    test_frame("stall_4_8", 4, 8, 1, 0);
    test_frame("busy_start", 4, 8, 0, 1);
    test_reset_mid;
    test_frame("stall_7_3", 7, 3, 1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
